// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: instruction-in / immediate-out handshake bundle for imm_decode_stage.
interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decoder with a main + skid buffer for full-rate back-pressure.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                sel_en,
    input  logic [2:0]          sel,
    imm_decode_stage_if.slave   bus
);
    localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3, F_J = 3'd4, F_Z = 3'd5, F_N = 3'd7;
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;
    localparam entry_t E_RST = '{imm: '0, fmt: F_N, ill: 1'b0, tag: '0};
    logic [31:0]     w_i;
    logic [2:0]      w_auto_fmt, w_fmt;
    logic            w_auto_ill, w_ill, w_acc;
    logic [31:0]     w_imm32;
    entry_t          w_new, r_main, r_skid;
    logic            r_m_valid, r_s_valid;
    assign w_i = bus.in_instr;
    always_comb begin
        w_auto_fmt = F_N;
        w_auto_ill = 1'b1;
        case (w_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: {w_auto_fmt, w_auto_ill} = {F_I, 1'b0};
            7'b1110011: {w_auto_fmt, w_auto_ill} = {w_i[14] ? F_Z : F_I, 1'b0};
            7'b0100011: {w_auto_fmt, w_auto_ill} = {F_S, 1'b0};
            7'b1100011: {w_auto_fmt, w_auto_ill} = {F_B, 1'b0};
            7'b0110111, 7'b0010111: {w_auto_fmt, w_auto_ill} = {F_U, 1'b0};
            7'b1101111: {w_auto_fmt, w_auto_ill} = {F_J, 1'b0};
            7'b0110011: w_auto_ill = 1'b0;
            7'b0011011: {w_auto_fmt, w_auto_ill} = (XLEN == 64) ? {F_I, 1'b0} : {F_N, 1'b1};
            7'b0111011: w_auto_ill = (XLEN != 64);
            default: ;
        endcase
    end
    assign w_fmt = sel_en ? ((sel[2] & sel[1]) ? F_N : sel) : w_auto_fmt;
    assign w_ill = sel_en ? (sel[2] & sel[1]) : w_auto_ill;
    // Every format fits in 32 bits; Z has bit 31 clear so the final sign-extension keeps it zero-extended.
    assign w_imm32 = (w_fmt == F_I) ? {{20{w_i[31]}}, w_i[31:20]} :
                     (w_fmt == F_S) ? {{20{w_i[31]}}, w_i[31:25], w_i[11:7]} :
                     (w_fmt == F_B) ? {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
                     (w_fmt == F_U) ? {w_i[31:12], 12'b0} :
                     (w_fmt == F_J) ? {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} :
                     (w_fmt == F_Z) ? {27'b0, w_i[19:15]} : 32'b0;
    assign w_new = '{imm: XLEN'($signed(w_imm32)), fmt: w_fmt, ill: w_ill, tag: bus.in_tag};
    assign w_acc = bus.in_valid & ~r_s_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_main    <= E_RST;
            r_skid    <= E_RST;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || bus.out_ready) begin
            r_m_valid <= r_s_valid | w_acc;
            r_s_valid <= 1'b0;
            if (r_s_valid) r_main <= r_skid;
            else if (w_acc) r_main <= w_new;
        end else if (w_acc) begin
            r_skid    <= w_new;
            r_s_valid <= 1'b1;
        end
    end
    assign bus.in_ready    = ~r_s_valid;
    assign bus.out_valid   = r_m_valid;
    assign bus.out_imm     = r_main.imm;
    assign bus.out_fmt     = r_main.fmt;
    assign bus.out_illegal = r_main.ill;
    assign bus.out_tag     = r_main.tag;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed vector table, buffer corner cases and randomized scoreboard run on XLEN=32 and XLEN=64 instances.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, sel_en, in_valid, out_ready;
    logic [2:0]  sel;
    logic [31:0] in_instr, in_tag;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();
    assign b32.in_valid = in_valid;
    assign b32.in_instr = in_instr;
    assign b32.in_tag = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;
    assign b64.in_instr = in_instr;
    assign b64.in_tag = in_tag;
    assign b64.out_ready = out_ready;
    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .sel_en(sel_en), .sel(sel), .bus(b32.slave));
    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .sel_en(sel_en), .sel(sel), .bus(b64.slave));
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask
    typedef struct {
        logic [31:0] instr;
        logic        se;
        logic [2:0]  sel;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } res_t;
    typedef struct {
        logic [31:0] instr;
        logic        se;
        logic [2:0]  sel;
        logic [31:0] tag;
    } beat_t;
    // Reference decode straight from the format rules, using signed integer arithmetic.
    function automatic res_t ref_dec(input logic [31:0] ins, input logic se, input logic [2:0] s, input bit x64);
        res_t r;
        longint v;
        int f;
        r.ill = 1'b0;
        f = 7;
        if (se) begin
            if (s >= 3'd6) r.ill = 1'b1;
            else f = int'(s);
        end else begin
            case (ins[6:0])
                7'h03, 7'h13, 7'h67, 7'h0F: f = 0;
                7'h73: f = ins[14] ? 5 : 0;
                7'h23: f = 1;
                7'h63: f = 2;
                7'h37, 7'h17: f = 3;
                7'h6F: f = 4;
                7'h33: f = 7;
                7'h1B: if (x64) f = 0; else r.ill = 1'b1;
                7'h3B: r.ill = !x64;
                default: r.ill = 1'b1;
            endcase
        end
        case (f)
            0: v = $signed(ins[31:20]);
            1: v = $signed({ins[31:25], ins[11:7]});
            2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3: v = $signed({ins[31:12], 12'b0});
            4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        r.imm = x64 ? v : {32'b0, v[31:0]};
        r.fmt = 3'(f);
        return r;
    endfunction
    vec_t vecs [15];
    logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F};
    beat_t q [$];
    beat_t hd;
    res_t r32, r64;
    int got_tags [$];
    int nxt, tag_ctr;
    bit ir;
    initial begin
        vecs[0]  = '{32'hFFF00093, 1'b0, 3'd0, 32'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
        vecs[1]  = '{32'hFE112E23, 1'b0, 3'd0, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 1'b0, 3'd0, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        vecs[3]  = '{32'h123452B7, 1'b0, 3'd0, 32'h12345000, 3'd3, 1'b0, 64'h0000000012345000, 3'd3, 1'b0};
        vecs[4]  = '{32'h001000EF, 1'b0, 3'd0, 32'h00000800, 3'd4, 1'b0, 64'h0000000000000800, 3'd4, 1'b0};
        vecs[5]  = '{32'h00FFD073, 1'b0, 3'd0, 32'h0000001F, 3'd5, 1'b0, 64'h000000000000001F, 3'd5, 1'b0};
        vecs[6]  = '{32'h0000007F, 1'b0, 3'd0, 32'h00000000, 3'd7, 1'b1, 64'h0, 3'd7, 1'b1};
        vecs[7]  = '{32'hFFF00093, 1'b1, 3'd2, 32'hFFFFFFE0, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFE0, 3'd2, 1'b0};
        vecs[8]  = '{32'h800002B7, 1'b0, 3'd0, 32'h80000000, 3'd3, 1'b0, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
        vecs[9]  = '{32'h0010009B, 1'b0, 3'd0, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000001, 3'd0, 1'b0};
        vecs[10] = '{32'h00000033, 1'b0, 3'd0, 32'h00000000, 3'd7, 1'b0, 64'h0, 3'd7, 1'b0};
        vecs[11] = '{32'hFFF00093, 1'b1, 3'd6, 32'h00000000, 3'd7, 1'b1, 64'h0, 3'd7, 1'b1};
        vecs[12] = '{32'h0000003B, 1'b0, 3'd0, 32'h00000000, 3'd7, 1'b1, 64'h0, 3'd7, 1'b0};
        vecs[13] = '{32'h00500073, 1'b0, 3'd0, 32'h00000005, 3'd0, 1'b0, 64'h0000000000000005, 3'd0, 1'b0};
        vecs[14] = '{32'h00FFD073, 1'b1, 3'd5, 32'h0000001F, 3'd5, 1'b0, 64'h000000000000001F, 3'd5, 1'b0};
        rst = 1'b1; flush = 1'b0; sel_en = 1'b0; sel = 3'd0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_tag = 32'h0;
        #1;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
        chk("rst_out_fmt", 64'(b32.out_fmt), 64'd7);
        chk("rst_out_illegal", 64'(b32.out_illegal), 64'd0);
        chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Back-to-back vector table with out_ready=1: each result must appear exactly one cycle later.
        for (int i = 0; i <= 15; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("v%0d_valid", i-1), 64'(b32.out_valid), 64'd1);
                chk($sformatf("v%0d_imm32", i-1), 64'(b32.out_imm), 64'(vecs[i-1].imm32));
                chk($sformatf("v%0d_fmt32", i-1), 64'(b32.out_fmt), 64'(vecs[i-1].fmt32));
                chk($sformatf("v%0d_ill32", i-1), 64'(b32.out_illegal), 64'(vecs[i-1].ill32));
                chk($sformatf("v%0d_tag", i-1), 64'(b32.out_tag), 64'(i-1));
                chk($sformatf("v%0d_imm64", i-1), b64.out_imm, vecs[i-1].imm64);
                chk($sformatf("v%0d_fmt64", i-1), 64'(b64.out_fmt), 64'(vecs[i-1].fmt64));
                chk($sformatf("v%0d_ill64", i-1), 64'(b64.out_illegal), 64'(vecs[i-1].ill64));
            end
            if (i < 15) begin
                in_valid = 1'b1; in_instr = vecs[i].instr; sel_en = vecs[i].se; sel = vecs[i].sel; in_tag = 32'(i);
            end else in_valid = 1'b0;
        end
        sel_en = 1'b0;
        @(negedge clk);
        chk("drain_empty", 64'(b32.out_valid), 64'd0);
        // Four tagged beats with out_ready low for the first 3 cycles.
        nxt = 0;
        got_tags.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            if (c == 1) chk("bp_in_ready_after_1st", 64'(b32.in_ready), 64'd1);
            if (c == 2) chk("bp_in_ready_after_2nd", 64'(b32.in_ready), 64'd0);
            if (c == 2) chk("bp_hold_tag", 64'(b32.out_tag), 64'd0);
            if (b32.out_valid && out_ready) got_tags.push_back(int'(b32.out_tag));
            if (b32.in_ready && nxt < 4) begin
                in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'(nxt); nxt++;
            end else in_valid = 1'b0;
        end
        chk("bp_count", 64'(got_tags.size()), 64'd4);
        for (int k = 0; k < got_tags.size() && k < 4; k++) chk($sformatf("bp_order%0d", k), 64'(got_tags[k]), 64'(k));
        // Fill both entries, then flush with a beat presented.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'(10 + k);
        end
        @(negedge clk);
        chk("fl_full", 64'(b32.in_ready), 64'd0);
        flush = 1'b1; in_tag = 32'd12;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
        chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_no_ghost", 64'(b32.out_valid), 64'd0);
        end
        // Flush in the same cycle as a completed handshake: the beat is dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd20;
        @(negedge clk);
        in_tag = 32'd21; flush = 1'b1;
        chk("fl2_handshake", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl2_out_valid", 64'(b32.out_valid), 64'd0);
        @(negedge clk);
        chk("fl2_no_ghost", 64'(b32.out_valid), 64'd0);
        // Asynchronous reset between clock edges.
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd33; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_tag = 32'd34;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(b32.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(b32.out_valid), 64'd0);
        chk("ar_in_ready", 64'(b32.in_ready), 64'd1);
        chk("ar_out_imm", 64'(b32.out_imm), 64'd0);
        chk("ar_out_fmt", 64'(b32.out_fmt), 64'd7);
        chk("ar_out_tag", 64'(b32.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        // Randomized run against the queue model; occupancy 2 means the skid is full.
        q.delete();
        tag_ctr = 1000;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_instr = $urandom;
            if ($urandom_range(0, 3) != 0) in_instr[6:0] = ops[$urandom_range(0, 13)];
            sel_en = ($urandom_range(0, 3) == 0);
            sel = 3'($urandom_range(0, 7));
            in_tag = 32'(tag_ctr);
            chk("rnd_out_valid", 64'(b32.out_valid), 64'(q.size() != 0));
            chk("rnd_in_ready", 64'(b32.in_ready), 64'(q.size() < 2));
            chk("rnd_in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
            ir = (q.size() < 2);
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && out_ready) begin
                    hd = q.pop_front();
                    r32 = ref_dec(hd.instr, hd.se, hd.sel, 1'b0);
                    r64 = ref_dec(hd.instr, hd.se, hd.sel, 1'b1);
                    chk("rnd_imm32", 64'(b32.out_imm), r32.imm);
                    chk("rnd_fmt32", 64'(b32.out_fmt), 64'(r32.fmt));
                    chk("rnd_ill32", 64'(b32.out_illegal), 64'(r32.ill));
                    chk("rnd_tag32", 64'(b32.out_tag), 64'(hd.tag));
                    chk("rnd_imm64", b64.out_imm, r64.imm);
                    chk("rnd_fmt64", 64'(b64.out_fmt), 64'(r64.fmt));
                    chk("rnd_ill64", 64'(b64.out_illegal), 64'(r64.ill));
                    chk("rnd_tag64", 64'(b64.out_tag), 64'(hd.tag));
                end
                if (in_valid && ir) begin
                    q.push_back('{in_instr, sel_en, sel, in_tag});
                    tag_ctr++;
                end
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, pipelined immediate-decode stage between fetch and the register-read/execute path.
- Accepts a raw 32-bit instruction with a valid/ready handshake.
- Derives the immediate format from the opcode (or from an explicit select in override mode) and sign/zero-extends to XLEN.
- Emits immediate, format code, illegal flag and a passthrough tag one cycle later, through a 2-entry skid buffer for full throughput under back-pressure.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically the PC) carried alongside the instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; discards all buffered entries.
- sel_en  input  1  1 = use sel as format, 0 = auto-decode from opcode.
- sel  input  3  format override: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm); 110/111 illegal.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat; registered.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  format code; same encoding as sel; 111 = none/illegal.
- out_illegal  output  1  opcode or sel not recognised.
- out_tag  output  TAG_W  tag of the beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, in_ready=1, out_imm=0, out_fmt=3'b111, out_illegal=0, out_tag=0; both buffer entries invalid.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency and throughput: an accepted beat appears on out_* the next cycle (latency 1). Throughput is 1 beat/cycle while out_ready=1. Order is strictly preserved.
- Storage: main register drives out_*; a skid register holds one extra beat.
  - Accept while main empty or draining: beat goes to main.
  - Accept while main holds and out_ready=0: beat goes to skid; in_ready=0 from the next cycle.
  - Skid full and out_ready=1: skid moves to main, in_ready returns to 1 next cycle.
  - in_ready = !skid_valid, registered. It never depends combinationally on out_ready.
- Auto-decode (sel_en=0), by opcode in_instr[6:0]:
  - I format: 0000011, 0010011, 1100111, 0001111, and 1110011 with funct3[2]=0.
  - Z format: 1110011 with funct3[2]=1.
  - S format: 0100011. B format: 1100011. U format: 0110111, 0010111. J format: 1101111.
  - None (fmt 111, imm 0, not illegal): 0110011.
  - XLEN=64 only: 0011011 decodes as I; 0111011 decodes as none.
  - Any other opcode: fmt 111, imm 0, out_illegal=1.
- Format extraction, with sign bit = instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extended instr[19:15].
  - All formats except Z are sign-extended to XLEN.
- Override mode (sel_en=1): opcode is ignored. sel 110/111 gives fmt 111, imm 0, out_illegal=1.
- Flush:
  - flush=1 invalidates main and skid at the next edge: out_valid=0, in_ready=1.
  - A beat presented in the same cycle completes its handshake but is discarded.
  - Flush dominates both accept and drain.
- Stable hold: while out_valid=1 and out_ready=0, all out_* hold stable.
- Reset mid-operation: all pending beats are lost and outputs return immediately to their reset values.

Test Plan:
- XLEN=32, sel_en=0: 0xFFF00093, 0xFE112E23, 0xFE000CE3, 0x123452B7, 0x001000EF back-to-back with out_ready=1 -> one per cycle, 1-cycle latency.
  - Expected out_imm: 0xFFFFFFFF (I), 0xFFFFFFFC (S), 0xFFFFFFF8 (B), 0x12345000 (U), 0x00000800 (J).
- 0x00FFD073 (CSRRWI, zimm=31) -> out_fmt=101, out_imm=0x0000001F. 0x0000007F -> out_illegal=1, out_imm=0.
- Stream of 4 tagged beats, tags 0..3, with out_ready held 0 for 3 cycles:
  - in_ready drops one cycle after the 2nd accept.
  - No beat is lost or duplicated; tags emerge in order 0,1,2,3.
- Both entries full, then flush asserted with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle beat never appears.
- XLEN=64: 0x800002B7 -> 0xFFFFFFFF80000000; 0x0010009B (OP-IMM-32) -> fmt I, imm 1.
- sel_en=1, sel=010 on 0xFFF00093 -> B extraction 0xFFFFFFE0 (instr[7]=1 sets bit 11). Separately, rst pulsed mid-stream -> outputs reset asynchronously without waiting for a clock edge.
